// File: rtl/alu16_nibble_seq_if.sv
// Request/response bundle between a requester (CPU control) and the nibble-serial ALU.
// Latency: none, pure wiring; the ALU answers 4 cycles after an accepted start, done one cycle later.
// Backpressure: the requester sees busy and must hold off; a start while busy is dropped.
// Optional ovf signal is present only when ALU16_SEQ_OVF_EN is defined.
interface alu16_nibble_seq_if #(
    parameter int W = 16
);
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [5:0]   sel;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         zr;
    logic         ng;
`ifdef ALU16_SEQ_OVF_EN
    logic         ovf;

    modport master (output start, x, y, sel, input busy, done, out, zr, ng, ovf);
    modport slave  (input start, x, y, sel, output busy, done, out, zr, ng, ovf);
`else
    modport master (output start, x, y, sel, input busy, done, out, zr, ng);
    modport slave  (input start, x, y, sel, output busy, done, out, zr, ng);
`endif
endinterface

// File: rtl/alu16_nibble_seq.sv
// Sequential Hack ALU: one 4-bit ALU slice reused per nibble, carry registered between nibbles.
// Latency: start accepted at E0, nibbles written E1..E4, done pulses the cycle after E4.
// Backpressure: busy high in RUN, start ignored then; start in DONE chains straight into RUN.
// Optional feature macro: ALU16_SEQ_OVF_EN adds a signed-overflow output ovf.

// One 4-bit Hack ALU slice; sel = {zx,nx,zy,ny,f,no}.
module alu16_nibble_seq_alu4 (
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    input  logic [5:0] i_sel,
    input  logic       i_cin,
    output logic [3:0] o_out,
    output logic       o_cout
`ifdef ALU16_SEQ_OVF_EN
    ,
    output logic       o_xp_msb,
    output logic       o_yp_msb,
    output logic       o_sum_msb
`endif
);
    logic [3:0] w_xz, w_xp, w_yz, w_yp, w_sum;
    logic [4:0] w_add;

    assign w_xz   = i_sel[5] ? 4'h0 : i_x;
    assign w_xp   = i_sel[4] ? ~w_xz : w_xz;
    assign w_yz   = i_sel[3] ? 4'h0 : i_y;
    assign w_yp   = i_sel[2] ? ~w_yz : w_yz;
    assign w_add  = {1'b0, w_xp} + {1'b0, w_yp} + {4'h0, i_cin};
    assign w_sum  = i_sel[1] ? w_add[3:0] : (w_xp & w_yp);
    assign o_out  = i_sel[0] ? ~w_sum : w_sum;
    // The caller gates cout with f, so the raw adder carry is exported here.
    assign o_cout = w_add[4];
`ifdef ALU16_SEQ_OVF_EN
    assign o_xp_msb  = w_xp[3];
    assign o_yp_msb  = w_yp[3];
    assign o_sum_msb = w_sum[3];
`endif
endmodule

module alu16_nibble_seq #(
    parameter int NIB_CNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu16_nibble_seq_if.slave  bus
);
    localparam int W  = 4 * NIB_CNT;
    localparam int IW = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_y;
    logic [5:0]      r_sel;
    logic            r_carry;
    logic            r_zacc;
    logic [IW-1:0]   r_idx;
    logic            r_busy;
    logic            r_done;
    logic [W-1:0]    r_out;
    logic            r_zr;
    logic            r_ng;

    logic [3:0]      w_nib_x;
    logic [3:0]      w_nib_y;
    logic [3:0]      w_nib_out;
    logic            w_cout;
    logic            w_nib_zero;
    logic            w_last;

    assign w_nib_x    = r_x[4*r_idx +: 4];
    assign w_nib_y    = r_y[4*r_idx +: 4];
    assign w_nib_zero = (w_nib_out == 4'h0);
    assign w_last     = (r_idx == IW'(NIB_CNT - 1));

`ifdef ALU16_SEQ_OVF_EN
    logic            r_ovf;
    logic            w_xp_msb;
    logic            w_yp_msb;
    logic            w_sum_msb;
    logic            w_ovf;

    // Overflow only matters on the top nibble, which is the one in the slice when w_last is set.
    assign w_ovf   = r_sel[1] & (w_xp_msb == w_yp_msb) & (w_sum_msb != w_xp_msb);
    assign bus.ovf = r_ovf;
`endif

    alu16_nibble_seq_alu4 u_alu4 (
        .i_x       (w_nib_x),
        .i_y       (w_nib_y),
        .i_sel     (r_sel),
        .i_cin     (r_carry),
        .o_out     (w_nib_out),
        .o_cout    (w_cout)
`ifdef ALU16_SEQ_OVF_EN
        ,
        .o_xp_msb  (w_xp_msb),
        .o_yp_msb  (w_yp_msb),
        .o_sum_msb (w_sum_msb)
`endif
    );

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.out  = r_out;
    assign bus.zr   = r_zr;
    assign bus.ng   = r_ng;

    // Control FSM plus datapath registers; busy/done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_sel   <= '0;
            r_carry <= 1'b0;
            r_zacc  <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= '0;
            r_zr    <= 1'b0;
            r_ng    <= 1'b0;
`ifdef ALU16_SEQ_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                // IDLE and DONE both accept a new request; DONE chains without an IDLE bubble.
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_x     <= bus.x;
                        r_y     <= bus.y;
                        r_sel   <= bus.sel;
                        r_carry <= 1'b0;
                        r_zacc  <= 1'b1;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_out[4*r_idx +: 4] <= w_nib_out;
                    // With f=0 there is no arithmetic, so no carry may leak into the next nibble.
                    r_carry <= r_sel[1] & w_cout;
                    r_zacc  <= r_zacc & w_nib_zero;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_zr    <= r_zacc & w_nib_zero;
                        r_ng    <= w_nib_out[3];
`ifdef ALU16_SEQ_OVF_EN
                        r_ovf   <= w_ovf;
`endif
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
